// File: rtl/instr_fetch.sv
// Instruction fetch stage: program counter, IF/ID pipeline register and a RUN/HALT
// control FSM with redirect, stall, halt-on-word and sticky error flags.
module instr_fetch #(
  parameter logic [7:0]  RESET_PC  = 8'h00,
  parameter logic [15:0] HALT_WORD = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  imem_addr,
  input  logic [15:0] imem_instr,
  input  logic [7:0]  imem_addr_echo,
  input  logic        stall,
  input  logic        redirect,
  input  logic [7:0]  redirect_target,
  output logic [15:0] if_instr,
  output logic [7:0]  if_pc,
  output logic [7:0]  if_pc_plus2,
  output logic        if_valid,
  output logic        halted,
  output logic        fetch_err,
  output logic        misalign,
  output logic [15:0] fetch_count
);

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] if_instr_q, if_instr_d;
  logic [7:0]  if_pc_q, if_pc_d;
  logic [7:0]  if_pc_plus2_q, if_pc_plus2_d;
  logic        if_valid_q, if_valid_d;
  logic        fetch_err_q, fetch_err_d;
  logic        misalign_q, misalign_d;
  logic [15:0] fetch_count_q, fetch_count_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    if_pc_plus2_d = if_pc_plus2_q;
    if_valid_d    = if_valid_q;
    fetch_err_d   = fetch_err_q;
    misalign_d    = misalign_q;
    fetch_count_d = fetch_count_q;

    if (redirect) begin
      // Flush only drops the valid bit; the stale IF/ID payload is don't-care.
      pc_d       = {redirect_target[7:1], 1'b0};
      if_valid_d = 1'b0;
      state_d    = S_RUN;
      if (redirect_target[0]) misalign_d = 1'b1;
    end else if (stall) begin
      // Hold everything.
    end else if (state_q == S_RUN) begin
      if_instr_d    = imem_instr;
      if_pc_d       = pc_q;
      if_pc_plus2_d = pc_q + 8'd2;
      if_valid_d    = 1'b1;
      fetch_count_d = sat_inc16(fetch_count_q);
      if (imem_instr == HALT_WORD) state_d = S_HALT;
      else                         pc_d    = pc_q + 8'd2;
    end else begin
      if_valid_d = 1'b0;
    end

    // Echo check applies to every unstalled RUN edge, redirect or not.
    if (state_q == S_RUN && !stall && imem_addr_echo != pc_q) fetch_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_RUN;
      pc_q          <= RESET_PC;
      if_instr_q    <= 16'h0000;
      if_pc_q       <= 8'h00;
      if_pc_plus2_q <= 8'h00;
      if_valid_q    <= 1'b0;
      fetch_err_q   <= 1'b0;
      misalign_q    <= 1'b0;
      fetch_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      if_pc_plus2_q <= if_pc_plus2_d;
      if_valid_q    <= if_valid_d;
      fetch_err_q   <= fetch_err_d;
      misalign_q    <= misalign_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign if_pc_plus2 = if_pc_plus2_q;
  assign if_valid    = if_valid_q;
  assign halted      = (state_q == S_HALT);
  assign fetch_err   = fetch_err_q;
  assign misalign    = misalign_q;
  assign fetch_count = fetch_count_q;

endmodule
